// File: rtl/lower_lru_way_finder.sv
// -----------------------------------------------------------------------------
// lower_lru_way_finder
//
// Picks a victim way for one cache set from a per-way "recently used" bit
// vector. The victim is the lowest-numbered way whose LRU bit is 0. The block
// also produces the updated LRU vector for an access to that set. A registered
// copy of the victim result is captured on a sample strobe.
//
// Parameters
//   WAYS   number of cache ways (2..16)
//   IDX_W  way-index width, defaults to clog2(WAYS). It may be widened so that
//          access_way can carry out-of-range indices, which are then ignored.
//
// Ports
//   clk                      clock, rising edge
//   rst_n                    asynchronous active-low reset
//   current_lru   [WAYS]     per-way LRU bits, 1 = recently used
//   lru_valid                sample strobe for the registered result
//   way_offset_lower_lru_way [IDX_W] combinational victim index
//   all_used                 combinational flag, every way recently used
//   reg_way_offset [IDX_W]   registered victim index
//   reg_all_used             registered all_used
//   reg_valid                lru_valid delayed one cycle
//   access_valid             a way of this set is being accessed
//   access_way    [IDX_W]    index of the accessed way
//   next_lru      [WAYS]     combinational updated LRU vector
// -----------------------------------------------------------------------------
module lower_lru_way_finder #(
   parameter int WAYS  = 2,
   parameter int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WAYS-1:0]  current_lru,
   input  logic             lru_valid,
   output logic [IDX_W-1:0] way_offset_lower_lru_way,
   output logic             all_used,
   output logic [IDX_W-1:0] reg_way_offset,
   output logic             reg_all_used,
   output logic             reg_valid,
   input  logic             access_valid,
   input  logic [IDX_W-1:0] access_way,
   output logic [WAYS-1:0]  next_lru
);

   logic [IDX_W-1:0] victim_idx;
   logic [WAYS-1:0]  access_onehot;
   logic             access_in_range;

   // Scan from the top down so the last assignment wins with the lowest
   // free index. If no bit is clear the index stays at 0.
   always_comb begin
      victim_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!current_lru[i]) begin
            victim_idx = IDX_W'(i);
         end
      end
   end

   assign way_offset_lower_lru_way = victim_idx;
   assign all_used                 = &current_lru;

   // One-hot decode of the accessed way. An index at or beyond WAYS decodes
   // to all zeros and is treated as no access.
   always_comb begin
      access_onehot = '0;
      for (int i = 0; i < WAYS; i++) begin
         access_onehot[i] = (int'(access_way) == i);
      end
   end

   assign access_in_range = (int'(access_way) < WAYS);
   assign next_lru        = (access_valid && access_in_range) ? access_onehot
                                                              : current_lru;

   // Registered copy of the victim result; holds between samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_way_offset <= '0;
         reg_all_used   <= 1'b0;
         reg_valid      <= 1'b0;
      end else begin
         reg_valid <= lru_valid;
         if (lru_valid) begin
            reg_way_offset <= victim_idx;
            reg_all_used   <= all_used;
         end
      end
   end

endmodule

// File: tb/tb_lower_lru_way_finder.sv
module tb_lower_lru_way_finder;

   logic clk;
   logic rst_n;

   // 2-way instance
   logic [1:0] lru2;
   logic       lru_valid2;
   logic [0:0] way2;
   logic       all2;
   logic [0:0] reg_way2;
   logic       reg_all2;
   logic       reg_valid2;
   logic       acc_valid2;
   logic [0:0] acc_way2;
   logic [1:0] next2;

   // 4-way instance with a widened index so out-of-range accesses can be driven
   logic [3:0] lru4;
   logic       lru_valid4;
   logic [2:0] way4;
   logic       all4;
   logic [2:0] reg_way4;
   logic       reg_all4;
   logic       reg_valid4;
   logic       acc_valid4;
   logic [2:0] acc_way4;
   logic [3:0] next4;

   int checks;
   int errors;

   lower_lru_way_finder #(.WAYS(2)) u_dut2 (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .current_lru              (lru2),
      .lru_valid                (lru_valid2),
      .way_offset_lower_lru_way (way2),
      .all_used                 (all2),
      .reg_way_offset           (reg_way2),
      .reg_all_used             (reg_all2),
      .reg_valid                (reg_valid2),
      .access_valid             (acc_valid2),
      .access_way               (acc_way2),
      .next_lru                 (next2)
   );

   lower_lru_way_finder #(.WAYS(4), .IDX_W(3)) u_dut4 (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .current_lru              (lru4),
      .lru_valid                (lru_valid4),
      .way_offset_lower_lru_way (way4),
      .all_used                 (all4),
      .reg_way_offset           (reg_way4),
      .reg_all_used             (reg_all4),
      .reg_valid                (reg_valid4),
      .access_valid             (acc_valid4),
      .access_way               (acc_way4),
      .next_lru                 (next4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s got=%0h", tag, got);
      end
   endtask

   // Wait for a rising edge, then step past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Combinational sweep for WAYS=2: lru, expected index, expected all_used
   logic [1:0] sw_lru [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
   logic       sw_idx [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   logic       sw_all [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      lru2 = '0; lru_valid2 = 1'b0; acc_valid2 = 1'b0; acc_way2 = '0;
      lru4 = '0; lru_valid4 = 1'b0; acc_valid4 = 1'b0; acc_way4 = '0;

      #2;
      check("rst_reg_way2",   32'(reg_way2),   32'd0);
      check("rst_reg_all2",   32'(reg_all2),   32'd0);
      check("rst_reg_valid2", 32'(reg_valid2), 32'd0);
      check("rst_reg_valid4", 32'(reg_valid4), 32'd0);

      // Sample requested while reset is held must be lost
      lru2 = 2'b01; lru_valid2 = 1'b1;
      tick();
      check("rst_lost_valid2", 32'(reg_valid2), 32'd0);
      check("rst_lost_way2",   32'(reg_way2),   32'd0);
      lru_valid2 = 1'b0;

      // Combinational sweep, WAYS=2
      for (int i = 0; i < 4; i++) begin
         lru2 = sw_lru[i];
         #1;
         check($sformatf("way2_lru%b", sw_lru[i]), 32'(way2), 32'(sw_idx[i]));
         check($sformatf("all2_lru%b", sw_lru[i]), 32'(all2), 32'(sw_all[i]));
      end

      // Release reset between edges
      @(negedge clk);
      rst_n = 1'b1;

      // One-cycle sample of 01 -> reg 1 valid; then hold with valid low
      lru2 = 2'b01; lru_valid2 = 1'b1;
      tick();
      lru_valid2 = 1'b0;
      check("smp01_reg_way2",   32'(reg_way2),   32'd1);
      check("smp01_reg_valid2", 32'(reg_valid2), 32'd1);
      check("smp01_reg_all2",   32'(reg_all2),   32'd0);
      lru2 = 2'b11;
      tick();
      check("hold_reg_valid2", 32'(reg_valid2), 32'd0);
      check("hold_reg_way2",   32'(reg_way2),   32'd1);
      check("hold_reg_all2",   32'(reg_all2),   32'd0);

      // Sample 11 -> index 0, all_used
      lru_valid2 = 1'b1;
      tick();
      lru_valid2 = 1'b0;
      check("smp11_reg_way2", 32'(reg_way2), 32'd0);
      check("smp11_reg_all2", 32'(reg_all2), 32'd1);

      // Re-sample 01, then assert reset between edges
      lru2 = 2'b01; lru_valid2 = 1'b1;
      tick();
      check("pre_rst_valid2", 32'(reg_valid2), 32'd1);
      check("pre_rst_way2",   32'(reg_way2),   32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_way2",   32'(reg_way2),   32'd0);
      check("async_rst_all2",   32'(reg_all2),   32'd0);
      check("async_rst_valid2", 32'(reg_valid2), 32'd0);
      tick();
      check("rst_held_valid2", 32'(reg_valid2), 32'd0);
      lru_valid2 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Access update, WAYS=2
      lru2 = 2'b11; acc_valid2 = 1'b1; acc_way2 = 1'b0;
      #1; check("acc2_way0", 32'(next2), 32'b01);
      acc_way2 = 1'b1;
      #1; check("acc2_way1", 32'(next2), 32'b10);
      acc_valid2 = 1'b0;
      #1; check("acc2_none", 32'(next2), 32'b11);

      // WAYS=4 victim search
      lru4 = 4'b0111;
      #1; check("way4_0111", 32'(way4), 32'd3);
      check("all4_0111", 32'(all4), 32'd0);
      lru4 = 4'b1111;
      #1; check("way4_1111", 32'(way4), 32'd0);
      check("all4_1111", 32'(all4), 32'd1);
      lru4 = 4'b1011;
      #1; check("way4_1011", 32'(way4), 32'd2);
      lru4 = 4'b1110;
      #1; check("way4_1110", 32'(way4), 32'd0);

      // WAYS=4 access update including out-of-range indices
      lru4 = 4'b1111; acc_valid4 = 1'b1; acc_way4 = 3'd2;
      #1; check("acc4_way2", 32'(next4), 32'b0100);
      lru4 = 4'b1010; acc_way4 = 3'd5;
      #1; check("acc4_way5", 32'(next4), 32'b1010);
      acc_way4 = 3'd4;
      #1; check("acc4_way4", 32'(next4), 32'b1010);
      acc_way4 = 3'd3;
      #1; check("acc4_way3", 32'(next4), 32'b1000);
      acc_valid4 = 1'b0; acc_way4 = 3'd0;
      #1; check("acc4_none", 32'(next4), 32'b1010);

      // WAYS=4 registered sample
      @(negedge clk);
      lru4 = 4'b0111; lru_valid4 = 1'b1;
      tick();
      lru_valid4 = 1'b0;
      check("smp4_reg_way",   32'(reg_way4),   32'd3);
      check("smp4_reg_valid", 32'(reg_valid4), 32'd1);
      check("smp4_reg_all",   32'(reg_all4),   32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lower_lru_way_finder.md
LOWER_LRU_WAY_FINDER -- requirements
Module: lower_lru_way_finder

Interface
REQ-001 The block SHALL have parameter WAYS, default 2, giving the number of cache ways; legal range 2..16.
REQ-002 The block SHALL have derived parameter IDX_W, default clog2(WAYS), giving the way-index width; IDX_W SHALL be at least 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port current_lru, input, WAYS bits: per-way LRU bit for one set; 1 means recently used, 0 means replaceable.
REQ-006 The block SHALL have port lru_valid, input, 1 bit: sample strobe for the registered result.
REQ-007 The block SHALL have port way_offset_lower_lru_way, output, IDX_W bits: combinational victim-way index.
REQ-008 The block SHALL have port all_used, output, 1 bit: combinational flag, set when every current_lru bit is 1.
REQ-009 The block SHALL have port reg_way_offset, output, IDX_W bits: registered copy of way_offset_lower_lru_way.
REQ-010 The block SHALL have port reg_all_used, output, 1 bit: registered copy of all_used.
REQ-011 The block SHALL have port reg_valid, output, 1 bit: qualifies reg_way_offset and reg_all_used.
REQ-012 The block SHALL have port access_valid, input, 1 bit: marks a way access for this set.
REQ-013 The block SHALL have port access_way, input, IDX_W bits: index of the accessed way.
REQ-014 The block SHALL have port next_lru, output, WAYS bits: combinational updated LRU vector.

Function
REQ-015 way_offset_lower_lru_way SHALL equal the lowest index i for which current_lru[i]==0, with zero latency from current_lru.
REQ-016 When every current_lru bit is 1, way_offset_lower_lru_way SHALL be 0 and all_used SHALL be 1; otherwise all_used SHALL be 0.
REQ-017 The combinational outputs SHALL depend only on current_lru and SHALL NOT be affected by clk or rst_n.
REQ-018 On a rising clk edge with lru_valid=1, reg_way_offset and reg_all_used SHALL load the combinational results; the result is visible one cycle after sampling.
REQ-019 On a rising clk edge with lru_valid=0, reg_way_offset and reg_all_used SHALL hold their previous values.
REQ-020 reg_valid SHALL be lru_valid registered on every rising edge, so it is 1 exactly in the cycle after a sample.
REQ-021 When access_valid=1 and access_way<WAYS, next_lru SHALL be one-hot at bit access_way (the accessed bit 1, all others 0).
REQ-022 When access_valid=0, or when access_way>=WAYS, next_lru SHALL equal current_lru.
REQ-023 next_lru SHALL be combinational, with zero latency.
REQ-024 There SHALL be no internal state other than reg_way_offset, reg_all_used and reg_valid.
REQ-025 X or Z on current_lru SHALL NOT be required to be masked; the block is not responsible for X-propagation.

Reset
REQ-026 While rst_n=0, reg_way_offset SHALL be 0, reg_all_used SHALL be 0 and reg_valid SHALL be 0, applied immediately and independent of clk.
REQ-027 On rst_n deassertion, the registers SHALL resume sampling at the first rising clk edge with rst_n=1.
REQ-028 If reset is asserted in the same cycle as lru_valid=1, the sample SHALL be lost and reg_valid SHALL remain 0.

Verification
REQ-029 WAYS=2, sweep current_lru 00, 01, 10, 11 -> way_offset_lower_lru_way = 0, 1, 0, 0; all_used = 0, 0, 0, 1.
REQ-030 WAYS=2, current_lru=01 with lru_valid=1 for one cycle -> next cycle reg_way_offset=1, reg_valid=1; the following cycle reg_valid=0 and reg_way_offset stays 1.
REQ-031 WAYS=2, access_valid=1 with access_way=0 and then 1, current_lru=11 -> next_lru = 01 and then 10; with access_valid=0 -> next_lru=11.
REQ-032 WAYS=4, current_lru=0111 -> way_offset_lower_lru_way=3; current_lru=1111 -> 0 with all_used=1; access_way=2 -> next_lru=0100.
REQ-033 Assert rst_n=0 mid-operation, between clock edges, while reg_valid=1 and reg_way_offset=1 -> all three registered outputs go to 0 immediately, with no clock edge needed.
REQ-034 WAYS=4, access_valid=1 with access_way=5, current_lru=1010 -> next_lru=1010.
